// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and single-cycle key strobe.
//
// Drives one column low at a time and rotates it once per scan tick. A single low
// row, seen on the same column for DEBOUNCE_SCANS consecutive ticks, is accepted
// as a key press. The decoded code is presented on num with a one-cycle key_valid
// strobe. The column stays frozen until DEBOUNCE_SCANS consecutive ticks with no
// row low release the key.
//
// Ports:
//   Clk        system clock
//   Rst_n      synchronous active-low reset
//   filas      keypad rows, active-low, asynchronous to Clk
//   column     keypad column drive, active-low one-hot
//   num        last accepted key code (digits, A-D, * = F, # = E)
//   key_valid  one-cycle pulse on each accepted press
//   en         high while a key is held
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] filas,
  output logic [3:0] column,
  output logic [3:0] num,
  output logic       key_valid,
  output logic       en
);

  localparam int unsigned    DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]     CntDone = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  // Input synchroniser
  logic [3:0] sync_q;
  logic [3:0] rs_q;

  // Scan tick divider
  logic [DivW-1:0] div_q;
  logic            tick;

  // FSM state and registered outputs
  state_e     state_q;
  logic [3:0] column_q;
  logic [3:0] row_q;
  logic [3:0] cnt_q;
  logic [3:0] num_q;
  logic       key_valid_q;
  logic       en_q;

  // Derived combinational signals
  logic       rs_none;
  logic       rs_single;
  logic [3:0] col_next;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic [3:0] key_code;
  logic [3:0] cnt_inc;
  logic       cnt_done;

  // Two-flop synchroniser; idles high so reset looks like "no key".
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync_q <= 4'b1111;
      rs_q   <= 4'b1111;
    end else begin
      sync_q <= filas;
      rs_q   <= sync_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      div_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign tick = (div_q == DivLast);

  // Multiple low rows are not "single"; the FSM treats them as no valid key.
  always_comb begin
    rs_single = 1'b0;
    case (rs_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: rs_single = 1'b1;
      default:                            rs_single = 1'b0;
    endcase
  end

  assign rs_none = (rs_q == 4'b1111);

  // Rotate the active-low column: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  assign col_next = {column_q[2:0], column_q[3]};

  always_comb begin
    row_idx = 2'd0;
    case (row_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    col_idx = 2'd0;
    case (column_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Key map indexed by {row, column}.
  always_comb begin
    key_code = 4'h0;
    unique case ({row_idx, col_idx})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hF;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hE;
      4'hF: key_code = 4'hD;
    endcase
  end

  assign cnt_inc  = cnt_q + 4'd1;
  assign cnt_done = (cnt_inc == CntDone);

  // Scan / debounce FSM. All transitions happen on tick cycles only; the strobe
  // is cleared every cycle so it can never last more than one cycle.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      column_q    <= 4'b1110;
      row_q       <= 4'b1111;
      cnt_q       <= 4'd0;
      num_q       <= 4'h0;
      key_valid_q <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (rs_single) begin
              row_q   <= rs_q;
              cnt_q   <= 4'd1;
              state_q <= StDebounce;
            end else begin
              column_q <= col_next;
            end
          end
          StDebounce: begin
            if (rs_q == row_q) begin
              cnt_q <= cnt_inc;
              if (cnt_done) begin
                state_q     <= StPressed;
                num_q       <= key_code;
                key_valid_q <= 1'b1;
                en_q        <= 1'b1;
              end
            end else begin
              // Bounce or a different pattern: drop the candidate and move on.
              state_q  <= StIdle;
              column_q <= col_next;
              cnt_q    <= 4'd0;
            end
          end
          StPressed: begin
            if (rs_none) begin
              cnt_q   <= 4'd1;
              state_q <= StRelease;
            end
          end
          StRelease: begin
            if (rs_none) begin
              cnt_q <= cnt_inc;
              if (cnt_done) begin
                state_q  <= StIdle;
                en_q     <= 1'b0;
                column_q <= col_next;
                cnt_q    <= 4'd0;
              end
            end else begin
              // Release bounce: key is still considered held, no new strobe.
              state_q <= StPressed;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign column    = column_q;
  assign num       = num_q;
  assign key_valid = key_valid_q;
  assign en        = en_q;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans the 4x4 matrix keypad, debounces presses and presents one decoded key code with a single-cycle valid strobe.
- Sits directly upstream of the SCAAD control FSM and supplies the num key code it decodes: digits, A/B/C/D, * as F and # as E.
- The one-cycle strobe removes the FSM's need to act on level-held key codes.
- Also drives the keypad column lines and the key-held indicator.

Parameters:
- SCAN_DIV, 50000: Clk cycles per column dwell; a scan tick occurs once per dwell (1 ms at 50 MHz).
- DEBOUNCE_SCANS, 4: consecutive identical scan-tick samples required to accept a press or a release; legal range 2..15.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  synchronous active-low reset
- filas  in  4  keypad row inputs, active-low with external pull-ups, asynchronous to Clk
- column  out  4  keypad column drive, active-low one-hot
- num  out  4  last accepted key code; held until the next accepted press
- key_valid  out  1  one-cycle pulse when a new key is accepted
- en  out  1  high while a key is held (from PRESSED entry until release is accepted)

Behaviour:
- Reset (Rst_n=0 at a Clk edge) sets:
  - column=4'b1110, num=0, key_valid=0, en=0
  - state=IDLE, column index=0, debounce count=0, tick divider=0, synchroniser flops=4'b1111.
  - Reset mid-debounce or mid-press discards that press; no strobe is issued.
- Input synchronisation: filas passes through a 2-flop synchroniser (rs). All decisions use rs.
- Tick: divider counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle the count equals SCAN_DIV-1. Logic below acts only on tick cycles.
- Row validity: rs is "single" when exactly one bit is 0, "none" when rs=4'b1111. Two or more low bits count as invalid, treated as "none" for detection.
- Key map (row r = filas bit r, column c = column bit c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: F 0 E D
- IDLE:
  - On tick, if rs is single: latch row pattern, count=1, go to DEBOUNCE; the column is not advanced.
  - Otherwise advance column index (3 wraps to 0).
- DEBOUNCE (column frozen):
  - On tick, if rs equals the latched pattern: count+1.
  - When count reaches DEBOUNCE_SCANS: go to PRESSED, num<=map(row,col), key_valid=1 on the next cycle only, en=1.
  - If rs differs from the latched pattern: go to IDLE, advance column, count=0, no strobe.
- PRESSED (column frozen):
  - On tick, if rs is none: count=1, go to RELEASE.
  - Otherwise stay; no further strobes, so auto-repeat is forbidden.
- RELEASE (column frozen):
  - On tick, if rs is none: count+1. At DEBOUNCE_SCANS go to IDLE, en=0, advance column.
  - If any row is low: return to PRESSED; en stays 1 and no new strobe is issued (bounce on release).
- Latency: row stable low at the sampling tick T0 (including synchroniser delay) gives key_valid high exactly one cycle after tick T0+(DEBOUNCE_SCANS-1)·SCAN_DIV.
- Simultaneous keys:
  - Multiple rows low in one column is invalid: in IDLE the column advances; in DEBOUNCE the press is aborted.
  - A second key in a different column while one is held is invisible, because the column is frozen.
- key_valid never exceeds one cycle. It is never asserted twice without an intervening accepted release.
- column is always one-hot low (never all-high, never two low).

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
1. Reset: hold Rst_n=0 for 3 cycles with filas=4'b0000 -> column=4'b1110, num=0, key_valid=0, en=0. After release, column rotates 1110→1101→1011→0111→1110, changing every 4 cycles.
2. Clean press of key 6: drive filas=4'b1101 only while column=4'b1011, hold 40 cycles -> exactly one key_valid pulse, num=4'h6, en=1. Release filas=4'b1111 -> en falls after 3 "none" ticks and scanning resumes.
3. Bounce on press of key * (r3,c0): toggle filas between 4'b0111 and 4'b1111 every tick for 4 ticks -> no key_valid, num unchanged. Then hold stable -> one strobe with num=4'hF.
4. Bounce on release after # (num=4'hE): release, then a row goes low again on the second "none" tick -> no second strobe, en stays 1. After a clean 3-tick release, en=0.
5. Two rows low (filas=4'b1100 on column 2) -> no strobe and the column keeps rotating.
6. Reset asserted during DEBOUNCE of key A -> no strobe, num=0, column=4'b1110 the cycle after reset.
